// File: rtl/lcd_bus_receiver_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_if : HD44780-style 8-bit LCD write bus plus the optional read-back
// path driven by the receiver.
//   lcd_en  : enable strobe; a transfer is taken on its falling edge
//   lcd_rs  : 0 = command, 1 = character data
//   lcd_rw  : 0 = write, 1 = read
//   lcd_dat : bus data
//   dat_out : read-back data (receiver -> writer)
//   dat_oe  : read-back drive enable (receiver -> writer)
// master = LCD writer side, slave = lcd_bus_receiver side.
// ---------------------------------------------------------------------------
interface lcd_bus_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_dat;
  logic [7:0] dat_out;
  logic       dat_oe;

  modport master (output lcd_en, lcd_rs, lcd_rw, lcd_dat, input dat_out, dat_oe);
  modport slave  (input lcd_en, lcd_rs, lcd_rw, lcd_dat, output dat_out, dat_oe);
endinterface

// File: rtl/lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver : receive-side model of an 8-bit HD44780-style LCD.
// Synchronises the asynchronous bus, latches a transfer on each falling edge
// of the synchronised enable, decodes commands, keeps a 16x2 DDRAM image,
// cursor and mode flags, and models the controller busy interval.
//
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   bus           : lcd_bus_if.slave (lcd_en/rs/rw/dat in, dat_out/dat_oe out)
//   rd_addr/rd_char : combinational DDRAM read, index {line, col[3:0]}
//   ovr_clr       : clears the sticky overrun flag
//   cursor_addr   : DDRAM address (0x00-0x0F, 0x40-0x4F)
//   display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, bus8
//   busy          : busy interval active
//   cmd_valid / char_valid : one-cycle pulse per accepted command / character
//   overrun       : a write arrived while busy (sticky)
//
// Optional macro LCD_BUSY_READ_EN: enables read strobes (busy/address read
// and DDRAM read-back on dat_out/dat_oe). Undefined: reads are ignored and
// dat_out/dat_oe are held at 0.
// ---------------------------------------------------------------------------
module lcd_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 40,
  parameter int CLR_CYCLES  = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_bus_if.slave   bus,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  input  logic       ovr_clr,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       two_line,
  output logic       bus8,
  output logic       busy,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic       overrun
);
  localparam int CNT_MAX = (BUSY_CYCLES > CLR_CYCLES) ? BUSY_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Sample word layout: [10]=en [9]=rs [8]=rw [7:0]=dat
  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] sync_d [SYNC_STAGES];
  logic [10:0] prev_q, prev_d, samp;

  logic [7:0]       ddram_q [32];
  logic [7:0]       ddram_d [32];
  logic [6:0]       cursor_q, cursor_d;
  logic             disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
  logic             inc_q, inc_d, shift_q, shift_d, two_q, two_d, bus8_q, bus8_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmdv_q, cmdv_d, charv_q, charv_d, ovr_q, ovr_d;
  logic             strobe, ovr_set;
  logic [4:0]       cur_idx;

  // One cursor step with the 16x2 wrap (line 0 end -> line 1 start, etc.).
  function automatic logic [6:0] cur_step(input logic [6:0] c, input logic inc);
    if (inc) return (c[3:0] == 4'hF) ? {~c[6], 6'h00} : {c[6], 2'b00, c[3:0] + 4'd1};
    else     return (c[3:0] == 4'h0) ? {~c[6], 6'h0F} : {c[6], 2'b00, c[3:0] - 4'd1};
  endfunction

  assign samp    = sync_q[SYNC_STAGES-1];
  // prev_q holds the last sample taken while en was still high, so rs/rw/dat
  // come from a stable, fully synchronised word.
  assign strobe  = prev_q[10] & ~samp[10];
  assign cur_idx = {cursor_q[6], cursor_q[3:0]};
  assign busy    = (cnt_q != '0);

  always_comb begin
    sync_d[0] = {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_dat};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = samp;
  end

  always_comb begin
    ddram_d  = ddram_q;
    cursor_d = cursor_q;
    disp_d   = disp_q;
    curs_d   = curs_q;
    blink_d  = blink_q;
    inc_d    = inc_q;
    shift_d  = shift_q;
    two_d    = two_q;
    bus8_d   = bus8_q;
    cnt_d    = busy ? cnt_q - 1'b1 : cnt_q;
    cmdv_d   = 1'b0;
    charv_d  = 1'b0;
    ovr_set  = 1'b0;
    if (strobe && !prev_q[8]) begin
      if (busy) begin
        ovr_set = 1'b1;  // dropped; busy is deliberately not extended
      end else begin
        cnt_d = CNT_W'(BUSY_CYCLES);
        if (prev_q[9]) begin
          ddram_d[cur_idx] = prev_q[7:0];
          cursor_d         = cur_step(cursor_q, inc_q);
          charv_d          = 1'b1;
        end else begin
          cmdv_d = 1'b1;
          // Highest set bit selects the instruction.
          if (prev_q[7]) begin
            cursor_d = {prev_q[6], 2'b00, prev_q[3:0]};
          end else if (prev_q[6]) begin
            // CGRAM address: not modelled
          end else if (prev_q[5]) begin
            bus8_d = prev_q[4];
            two_d  = prev_q[3];
          end else if (prev_q[4]) begin
            if (!prev_q[3]) cursor_d = cur_step(cursor_q, prev_q[2]);
          end else if (prev_q[3]) begin
            disp_d  = prev_q[2];
            curs_d  = prev_q[1];
            blink_d = prev_q[0];
          end else if (prev_q[2]) begin
            inc_d   = prev_q[1];
            shift_d = prev_q[0];
          end else if (prev_q[1]) begin
            cursor_d = 7'h00;
            cnt_d    = CNT_W'(CLR_CYCLES);
          end else if (prev_q[0]) begin
            for (int i = 0; i < 32; i++) ddram_d[i] = 8'h20;
            cursor_d = 7'h00;
            inc_d    = 1'b1;
            cnt_d    = CNT_W'(CLR_CYCLES);
          end
        end
      end
    end
`ifdef LCD_BUSY_READ_EN
    // Data reads auto-step the cursor regardless of busy.
    if (strobe && prev_q[8] && prev_q[9]) cursor_d = cur_step(cursor_q, inc_q);
`endif
    ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
      prev_q   <= '0;
      cursor_q <= 7'h00;
      disp_q   <= 1'b0;
      curs_q   <= 1'b0;
      blink_q  <= 1'b0;
      inc_q    <= 1'b1;
      shift_q  <= 1'b0;
      two_q    <= 1'b0;
      bus8_q   <= 1'b1;
      cnt_q    <= '0;
      cmdv_q   <= 1'b0;
      charv_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      ddram_q  <= ddram_d;
      prev_q   <= prev_d;
      cursor_q <= cursor_d;
      disp_q   <= disp_d;
      curs_q   <= curs_d;
      blink_q  <= blink_d;
      inc_q    <= inc_d;
      shift_q  <= shift_d;
      two_q    <= two_d;
      bus8_q   <= bus8_d;
      cnt_q    <= cnt_d;
      cmdv_q   <= cmdv_d;
      charv_q  <= charv_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef LCD_BUSY_READ_EN
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;

  always_comb begin
    oe_d   = samp[10] & samp[8];
    dout_d = 8'h00;
    if (oe_d) dout_d = samp[9] ? ddram_q[cur_idx] : {busy, cursor_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dat_oe  = oe_q;
  assign bus.dat_out = dout_q;
`else
  assign bus.dat_oe  = 1'b0;
  assign bus.dat_out = 8'h00;
`endif

  assign rd_char     = ddram_q[rd_addr];
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign entry_inc   = inc_q;
  assign entry_shift = shift_q;
  assign two_line    = two_q;
  assign bus8        = bus8_q;
  assign cmd_valid   = cmdv_q;
  assign char_valid  = charv_q;
  assign overrun     = ovr_q;
endmodule
